reg_array_bank: RTL and testbench

//   Parametrised register array: DEPTH entries of WIDTH bits with per-entry valid flags.

---
 rtl/reg_array_bank.sv | 170 +++++++++++++++++
 tb/tb_reg_array_bank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_array_bank.sv
// Register array with per-entry valid flags, registered read port and sequenced bulk clear.
// Optional per-entry even parity: define REG_ARRAY_PARITY_EN.
module reg_array_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             rd_hit_o,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             par_err_o
);

    if (WIDTH < 1) begin : g_width_chk
        $error("reg_array_bank: WIDTH must be at least 1");
    end
    if (DEPTH < 2) begin : g_depth_chk
        $error("reg_array_bank: DEPTH must be at least 2");
    end

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic             busy;
    logic             wr_inr, rd_inr, wr_ok;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_word;
    logic             par_bad;

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_hit_q, rd_hit_d;
    logic             err_q, err_d;
    logic             par_err_q, par_err_d;

    assign busy    = (state_q == S_CLEAR);
    assign wr_inr  = ({1'b0, wr_addr_i} < DEPTH_W);
    assign rd_inr  = ({1'b0, rd_addr_i} < DEPTH_W);
    assign wr_ok   = wr_en_i & ~busy & wr_inr;
    // Clamp so an out-of-range read never indexes past the array
    assign rd_idx  = rd_inr ? rd_addr_i : '0;
    assign rd_word = mem_q[rd_idx];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && idx_q == AW'(i)) begin
                    mem_q[i] <= RESET_VALUE;
                    vld_q[i] <= 1'b0;
                end else if (wr_ok && wr_addr_i == AW'(i)) begin
                    mem_q[i] <= wr_data_i;
                    vld_q[i] <= 1'b1;
                end
            end
        end
    end

`ifdef REG_ARRAY_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q <= {DEPTH{^RESET_VALUE}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && idx_q == AW'(i)) begin
                    par_q[i] <= ^RESET_VALUE;
                end else if (wr_ok && wr_addr_i == AW'(i)) begin
                    par_q[i] <= ^wr_data_i;
                end
            end
        end
    end

    assign par_bad = (^rd_word) != par_q[rd_idx];
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en_i;
        rd_hit_d   = rd_en_i & rd_inr & vld_q[rd_idx];
        par_err_d  = rd_en_i & rd_inr & par_bad;
        err_d      = (wr_en_i & (busy | ~wr_inr)) | (rd_en_i & ~rd_inr);
        if (rd_en_i) begin
            rd_data_d = rd_inr ? rd_word : RESET_VALUE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            err_q      <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            err_q      <= err_d;
            par_err_q  <= par_err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_hit_o   = rd_hit_q;
    assign err_o      = err_q;
    assign par_err_o  = par_err_q;
    assign busy_o     = busy;

endmodule

// File: tb/tb_reg_array_bank.sv
// Directed bench for reg_array_bank: DEPTH=8 main instance plus a DEPTH=6 instance
// for out-of-range addressing.
module tb_reg_array_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, clr = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       rd_valid, rd_hit, busy, err, par_err;

    logic       wr_en6 = 1'b0, rd_en6 = 1'b0, clr6 = 1'b0;
    logic [2:0] wr_addr6 = '0, rd_addr6 = '0;
    logic [7:0] wr_data6 = '0;
    logic [7:0] rd_data6;
    logic       rd_valid6, rd_hit6, busy6, err6, par_err6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_array_bank dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_hit_o(rd_hit),
        .clr_i(clr), .busy_o(busy), .err_o(err), .par_err_o(par_err)
    );

    reg_array_bank #(.DEPTH(6)) dut6 (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en6), .wr_addr_i(wr_addr6), .wr_data_i(wr_data6),
        .rd_en_i(rd_en6), .rd_addr_i(rd_addr6),
        .rd_data_o(rd_data6), .rd_valid_o(rd_valid6), .rd_hit_o(rd_hit6),
        .clr_i(clr6), .busy_o(busy6), .err_o(err6), .par_err_o(par_err6)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_data, rd_valid, rd_hit, busy, err, par_err} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0000",
                     {rd_data, rd_valid, rd_hit, busy, err, par_err});
        end
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1;
            rd_addr = 3'(a);
            tick();
            checks++;
            if ({rd_valid, rd_hit, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_read[%0d] got v=%b h=%b d=%h exp v=1 h=0 d=00",
                         a, rd_valid, rd_hit, rd_data);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_write_read;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd3;
        tick();
        checks++;
        if ({rd_valid, rd_hit, rd_data} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL wr_rd_a5 got v=%b h=%b d=%h exp v=1 h=1 d=a5",
                     rd_valid, rd_hit, rd_data);
        end
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks++;
        if (rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL same_cycle_old got %h exp a5", rd_data);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_hit, rd_data} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL later_read_new got h=%b d=%h exp h=1 d=3c", rd_hit, rd_data);
        end
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL rd_hold got v=%b d=%h exp v=0 d=3c", rd_valid, rd_data);
        end
    endtask

    task automatic test_clear;
        int cnt;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = busy ? 1 : 0;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'h77; clr = 1'b1;
        tick();
        wr_en = 1'b0; clr = 1'b0;
        if (busy) cnt++;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL clear_wr_err got %b exp 1", err);
        end
        tick();
        if (busy) cnt++;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL clear_err_pulse got %b exp 0", err);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!busy) break;
            cnt++;
        end
        checks++;
        if (cnt != 8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_len got %0d busy=%b exp 8 busy=0", cnt, busy);
        end
        for (int a = 0; a < 8; a++) begin
            rd_en = 1'b1; rd_addr = 3'(a);
            tick();
            checks++;
            if ({rd_valid, rd_hit, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL cleared_read[%0d] got v=%b h=%b d=%h exp v=1 h=0 d=00",
                         a, rd_valid, rd_hit, rd_data);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_clr_with_write;
        int n;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55; clr = 1'b1;
        tick();
        wr_en = 1'b0; clr = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_hit, rd_data} !== {1'b1, 8'h55}) begin
            errors++;
            $display("FAIL clr_wr_landed got h=%b d=%h exp h=1 d=55", rd_hit, rd_data);
        end
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_wr_timeout got busy=%b exp 0", busy);
        end
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_hit, rd_data} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL clr_wr_swept got h=%b d=%h exp h=0 d=00", rd_hit, rd_data);
        end
    endtask

    task automatic test_out_of_range;
        wr_en6 = 1'b1; wr_addr6 = 3'd5; wr_data6 = 8'h5A;
        tick();
        checks++;
        if (err6 !== 1'b0) begin
            errors++;
            $display("FAIL oor_good_wr_err got %b exp 0", err6);
        end
        wr_addr6 = 3'd7; wr_data6 = 8'hEE;
        tick();
        wr_en6 = 1'b0;
        checks++;
        if (err6 !== 1'b1) begin
            errors++;
            $display("FAIL oor_wr_err got %b exp 1", err6);
        end
        rd_en6 = 1'b1; rd_addr6 = 3'd7;
        tick();
        checks++;
        if ({rd_valid6, rd_hit6, rd_data6, err6} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL oor_rd got v=%b h=%b d=%h e=%b exp v=1 h=0 d=00 e=1",
                     rd_valid6, rd_hit6, rd_data6, err6);
        end
        rd_addr6 = 3'd5;
        tick();
        rd_en6 = 1'b0;
        checks++;
        if ({rd_hit6, rd_data6, err6} !== {1'b1, 8'h5A, 1'b0}) begin
            errors++;
            $display("FAIL oor_addr5 got h=%b d=%h e=%b exp h=1 d=5a e=0",
                     rd_hit6, rd_data6, err6);
        end
    endtask

    task automatic test_parity;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h0F;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, par_err, rd_data} !== {1'b1, 1'b0, 8'h0F}) begin
            errors++;
            $display("FAIL par_clean got v=%b p=%b d=%h exp v=1 p=0 d=0f",
                     rd_valid, par_err, rd_data);
        end
`ifdef REG_ARRAY_PARITY_EN
        dut.mem_q[2][0] = ~dut.mem_q[2][0];
        rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, par_err, rd_data} !== {1'b1, 1'b1, 8'h0E}) begin
            errors++;
            $display("FAIL par_flip got v=%b p=%b d=%h exp v=1 p=1 d=0e",
                     rd_valid, par_err, rd_data);
        end
`endif
    endtask

    task automatic test_reset_mid_clear;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h44;
        tick();
        wr_en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        rd_en = 1'b1; rd_addr = 3'd4;
        repeat (3) tick();
        checks++;
        if ({busy, rd_valid, rd_hit, rd_data} !== {1'b1, 1'b1, 1'b1, 8'h44}) begin
            errors++;
            $display("FAIL mid_clear_read got b=%b v=%b h=%b d=%h exp b=1 v=1 h=1 d=44",
                     busy, rd_valid, rd_hit, rd_data);
        end
        #2 rst = 1'b1;
        #1;
        rd_en = 1'b0;
        checks++;
        if ({rd_data, rd_valid, rd_hit, busy, err, par_err} !== 13'h0) begin
            errors++;
            $display("FAIL async_rst got %h exp 0000",
                     {rd_data, rd_valid, rd_hit, busy, err, par_err});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_idle got busy=%b exp 0", busy);
        end
        rd_en = 1'b1; rd_addr = 3'd4;
        tick();
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, rd_hit, rd_data} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL post_rst_read got v=%b h=%b d=%h exp v=1 h=0 d=00",
                     rd_valid, rd_hit, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_clear();
        test_clr_with_write();
        test_out_of_range();
        test_parity();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
